uart_rx_word: RTL and testbench

- Standalone serial-line receiver: samples RsRx directly (8N1, LSB first), packs 8 consecutive bytes into one 64-bit AXI-Stream word.
- Receive-only complement to the 64-bit-to-byte transmit path.
- Owns its own bit-timing engine, so no separate byte UART is needed.
- Adds frame-error, overrun and inter-byte timeout detection for host-link robustness.

---
 rtl/uart_rx_word.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_word.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// 8N1 serial receiver packing eight bytes (first byte in [7:0]) into one 64-bit AXI-Stream word.
// tvalid rises 1 cycle after the last stop sample; output reg + pending reg absorb stalls, a further word overruns.
module uart_rx_word #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned IDLE_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RsRx,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        rx_busy,
  output logic        frame_error,
  output logic        overrun_error,
  output logic        timeout_error
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] TO_LAST   = 32'(IDLE_TIMEOUT - 1);
  localparam bit          TO_EN     = (IDLE_TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        sync1, rx_s;
  logic [15:0] timer;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic [2:0]  count;
  logic [63:0] asm_buf;
  logic [63:0] pend_buf;
  logic        pend_vld;
  logic [15:0] idle_tick;
  logic [31:0] idle_bits;

  logic        byte_good, word_done, timeout_hit, slot_free;
  logic [63:0] new_word;

  always_comb begin
    byte_good   = (state == STOP) && (timer == 16'd0) && rx_s;
    word_done   = byte_good && (count == 3'd7);
    new_word    = {shreg, asm_buf[55:0]};
    timeout_hit = TO_EN && (state == IDLE) && (count != 3'd0) &&
                  (idle_tick == BIT_LAST) && (idle_bits == TO_LAST);
    slot_free   = !m_axis_tvalid || m_axis_tready;
  end

  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RsRx;
      rx_s  <= sync1;
    end
  end

  // Bit-timing engine: start validated at mid-bit, data/stop sampled one bit apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= 16'd0;
      idx         <= 3'd0;
      shreg       <= 8'd0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            timer <= HALF_LAST;
          end
        end
        START: begin
          if (timer == 16'd0) begin
            if (!rx_s) begin
              state <= DATA;
              idx   <= 3'd0;
              timer <= BIT_LAST;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DATA: begin
          if (timer == 16'd0) begin
            shreg[idx] <= rx_s;
            timer      <= BIT_LAST;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        STOP: begin
          if (timer == 16'd0) begin
            state <= IDLE;
            if (!rx_s) frame_error <= 1'b1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= 3'd0;
      asm_buf       <= 64'd0;
      idle_tick     <= 16'd0;
      idle_bits     <= 32'd0;
      timeout_error <= 1'b0;
    end else begin
      timeout_error <= 1'b0;
      if (byte_good) begin
        asm_buf[{count, 3'b000} +: 8] <= shreg;
        count <= count + 3'd1;
        if (count == 3'd7) asm_buf <= 64'd0;
      end else if (timeout_hit) begin
        timeout_error <= 1'b1;
        count         <= 3'd0;
        asm_buf       <= 64'd0;
      end
      // Idle timer only runs while a partial word sits waiting between frames.
      if (TO_EN && !timeout_hit && (state == IDLE) && (count != 3'd0)) begin
        if (idle_tick == BIT_LAST) begin
          idle_tick <= 16'd0;
          idle_bits <= idle_bits + 32'd1;
        end else begin
          idle_tick <= idle_tick + 16'd1;
        end
      end else begin
        idle_tick <= 16'd0;
        idle_bits <= 32'd0;
      end
    end
  end

  // Output slot is refilled from the pending word first, so word order is preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= 64'd0;
      m_axis_tvalid <= 1'b0;
      pend_buf      <= 64'd0;
      pend_vld      <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      if (slot_free) begin
        if (pend_vld) begin
          m_axis_tdata  <= pend_buf;
          m_axis_tvalid <= 1'b1;
          if (word_done) pend_buf <= new_word;
          else           pend_vld <= 1'b0;
        end else if (word_done) begin
          m_axis_tdata  <= new_word;
          m_axis_tvalid <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end else if (word_done) begin
        if (!pend_vld) begin
          pend_buf <= new_word;
          pend_vld <= 1'b1;
        end else begin
          overrun_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Scoreboard bench for uart_rx_word: serial stimulus pushes expected words, a monitor checks each transfer.
module tb_uart_rx_word;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        busy, fe, ov, to;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0, ov_cnt = 0, to_cnt = 0, vld_cycles = 0;
  logic [63:0] exp_q[$];
  logic        prev_hold = 1'b0;
  logic [63:0] prev_dat  = 64'd0;

  uart_rx_word #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .RsRx(rx),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .rx_busy(busy), .frame_error(fe), .overrun_error(ov), .timeout_error(to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted word, tallies error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
      if (to) to_cnt++;
      if (tvalid) vld_cycles++;
      if (prev_hold && tvalid) chk("tdata_stable", tdata, prev_dat);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) chk("unexpected_word", tdata, 64'hx);
        else chk("word", tdata, exp_q.pop_front());
      end
      prev_hold = tvalid && !tready;
      prev_dat  = tdata;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [63:0] w, input logic expect_it);
    if (expect_it) exp_q.push_back(w);
    for (int i = 0; i < 8; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic clear_counts();
    fe_cnt = 0; ov_cnt = 0; to_cnt = 0; vld_cycles = 0;
  endtask

  task automatic check_errs(input string name, input int e_fe, input int e_ov, input int e_to);
    chk({name, "_frame_err"},   64'(fe_cnt), 64'(e_fe));
    chk({name, "_overrun_err"}, 64'(ov_cnt), 64'(e_ov));
    chk({name, "_timeout_err"}, 64'(to_cnt), 64'(e_to));
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_flags", {60'd0, busy, fe, ov, to}, 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single word, always ready
    clear_counts();
    send_word(64'h0807060504030201, 1'b1);
    drain("t1");
    chk("t1_vld_cycles", 64'(vld_cycles), 64'd1);
    check_errs("t1", 0, 0, 0);

    // 2: stall across three words, third overruns
    clear_counts();
    tready = 1'b0;
    send_word(64'h1716151413121110, 1'b1);
    send_word(64'h1F1E1D1C1B1A1918, 1'b1);
    send_word(64'hA7A6A5A4A3A2A1A0, 1'b0);
    repeat (8) @(negedge clk);
    chk("t2_held_valid", 64'(tvalid), 64'd1);
    chk("t2_held_data", tdata, 64'h1716151413121110);
    check_errs("t2", 0, 1, 0);
    tready = 1'b1;
    drain("t2");
    chk("t2_overrun_after", 64'(ov_cnt), 64'd1);

    // 3: bad stop bit, then a clean word
    clear_counts();
    send_byte(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    send_word(64'h0706050403020100, 1'b1);
    drain("t3");
    check_errs("t3", 1, 0, 0);

    // 4: short low glitch on idle line
    clear_counts();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("t4_idle_after_glitch", 64'(busy), 64'd0);
    send_word(64'hFFFFFFFFFFFFFFFF, 1'b1);
    drain("t4");
    check_errs("t4", 0, 0, 0);

    // 5: partial word times out
    clear_counts();
    for (int i = 0; i < 3; i++) send_byte(8'hAA, 1'b1);
    repeat (5 * CPB) @(negedge clk);
    chk("t5_timeout_seen", 64'(to_cnt), 64'd1);
    send_word(64'h1111111111111111, 1'b1);
    drain("t5");
    check_errs("t5", 0, 0, 1);

    // 6: reset in the middle of byte 5
    clear_counts();
    for (int i = 0; i < 4; i++) send_byte(8'h21 + 8'(i), 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    chk("t6_busy_mid_data", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tdata", tdata, 64'd0);
    chk("t6_rst_flags", {59'd0, tvalid, busy, fe, ov, to}, 64'd0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    clear_counts();
    send_word(64'h2827262524232221, 1'b1);
    drain("t6");
    check_errs("t6", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
